// File: rtl/spi_sclk_bit_timer.sv
// SPI serial-clock generator: divides clk into SCLK, flags every SCLK edge,
// splits edges into sample/shift strobes by CPHA, and counts completed bits per word.
module spi_sclk_bit_timer #(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    localparam int DW = $clog2(CLK_DIV),
    localparam int BW = ($clog2(WORD_BITS) > 1) ? $clog2(WORD_BITS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          EnSCLK,
    input  logic          EnCounter,
    output logic          SCLK,
    output logic          SCLKEdgeFlg,
    output logic          SampleFlg,
    output logic          ShiftFlg,
    output logic          WordFlg,
    output logic [BW-1:0] BitCount
);

    logic [DW-1:0] div_cnt;
    logic          toggle;
    logic          leading;
    logic          trail_evt;

    assign toggle    = (div_cnt == DW'(CLK_DIV - 1));
    // SCLK still at its idle level means the coming toggle is a leading edge
    assign leading   = (SCLK == CPOL);
    assign trail_evt = EnSCLK && toggle && !leading;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            SCLK        <= CPOL;
            SCLKEdgeFlg <= 1'b0;
            SampleFlg   <= 1'b0;
            ShiftFlg    <= 1'b0;
            WordFlg     <= 1'b0;
            BitCount    <= '0;
        end else begin
            SCLKEdgeFlg <= 1'b0;
            SampleFlg   <= 1'b0;
            ShiftFlg    <= 1'b0;
            WordFlg     <= 1'b0;

            // Disabling discards any partially elapsed half-period
            if (!EnSCLK) begin
                div_cnt <= '0;
                SCLK    <= CPOL;
            end else if (toggle) begin
                div_cnt     <= '0;
                SCLK        <= ~SCLK;
                SCLKEdgeFlg <= 1'b1;
                SampleFlg   <= (leading != CPHA);
                ShiftFlg    <= (leading == CPHA);
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (!EnCounter) begin
                BitCount <= '0;
            end else if (trail_evt) begin
                if (BitCount == BW'(WORD_BITS - 1)) begin
                    BitCount <= '0;
                    WordFlg  <= 1'b1;
                end else begin
                    BitCount <= BitCount + 1'b1;
                end
            end
        end
    end

endmodule
